dmem_arb6: RTL and testbench

//   Two-port arbiter and storage for the 8 x 6-bit data memory of the 6-bit CPU.

---
 rtl/dmem_arb6.sv | 136 +++++++++++++
 tb/tb_dmem_arb6.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arb6.sv
// dmem_arb6: shared 8 x 6-bit data memory for the 6-bit CPU.
// One access per cycle between the CPU execute stage and a host/debug port.
// Conflicts are resolved round-robin, with an optional bounded host lock.
module dmem_arb6 #(
  parameter int DW         = 6,
  parameter int AW         = 3,
  parameter int LOCK_MAX   = 4,
  parameter int CLR_ON_RST = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  input  logic          host_lock,
  output logic [7:0]    conflict_cnt
);

  localparam int DEPTH = 2 ** AW;
  localparam int LW    = $clog2(LOCK_MAX + 1);

  typedef enum logic {WIN_CPU = 1'b0, WIN_HOST = 1'b1} win_t;

  win_t          r_last_win;
  logic [LW-1:0] r_lock_cnt;
  logic          r_host_lock_q;
  logic [DW-1:0] r_mem [DEPTH];
  logic          r_cpu_vld_p1;
  logic [DW-1:0] r_cpu_rdata_p1;
  logic          r_host_vld_p1;
  logic [DW-1:0] r_host_rdata_p1;
  logic [7:0]    r_conflict_cnt;

  logic w_cpu_gnt;
  logic w_host_gnt;
  logic w_lock_act;
  logic w_conflict;

  // Saturating 8-bit increment for the conflict counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_conflict = cpu_req && host_req;
  assign w_lock_act = r_host_lock_q && (r_lock_cnt < LW'(LOCK_MAX));

  // Grant selection: single requester wins; on conflict lock first, then round-robin.
  always_comb begin
    w_cpu_gnt  = 1'b0;
    w_host_gnt = 1'b0;
    if (!rst) begin
      if (w_conflict) begin
        if (w_lock_act)                   w_host_gnt = 1'b1;
        else if (r_last_win == WIN_HOST)  w_cpu_gnt  = 1'b1;
        else                              w_host_gnt = 1'b1;
      end else if (cpu_req) begin
        w_cpu_gnt = 1'b1;
      end else if (host_req) begin
        w_host_gnt = 1'b1;
      end
    end
  end

  // Arbitration state: last winner, host lock request and locked-win count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_win    <= WIN_HOST;
      r_lock_cnt    <= '0;
      r_host_lock_q <= 1'b0;
    end else if (w_cpu_gnt) begin
      r_last_win <= WIN_CPU;
      r_lock_cnt <= '0;
    end else if (w_host_gnt) begin
      r_last_win    <= WIN_HOST;
      r_host_lock_q <= host_lock;
      if (!host_lock)
        r_lock_cnt <= '0;
      else if (w_lock_act && cpu_req)
        r_lock_cnt <= r_lock_cnt + LW'(1);
    end
  end

  // Memory array: at most one granted write per cycle; optional clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLR_ON_RST != 0) begin
        for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end
    end else if (w_cpu_gnt && cpu_we) begin
      r_mem[cpu_addr] <= cpu_wdata;
    end else if (w_host_gnt && host_we) begin
      r_mem[host_addr] <= host_wdata;
    end
  end

  // Read return stage p1: data registered one cycle after the granted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_vld_p1    <= 1'b0;
      r_cpu_rdata_p1  <= '0;
      r_host_vld_p1   <= 1'b0;
      r_host_rdata_p1 <= '0;
    end else begin
      r_cpu_vld_p1  <= w_cpu_gnt && !cpu_we;
      r_host_vld_p1 <= w_host_gnt && !host_we;
      if (w_cpu_gnt && !cpu_we)   r_cpu_rdata_p1  <= r_mem[cpu_addr];
      if (w_host_gnt && !host_we) r_host_rdata_p1 <= r_mem[host_addr];
    end
  end

  // Count cycles in which both ports request, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst)             r_conflict_cnt <= 8'd0;
    else if (w_conflict) r_conflict_cnt <= sat_inc8(r_conflict_cnt);
  end

  assign cpu_gnt      = w_cpu_gnt;
  assign host_gnt     = w_host_gnt;
  assign cpu_rvalid   = r_cpu_vld_p1;
  assign cpu_rdata    = r_cpu_rdata_p1;
  assign host_rvalid  = r_host_vld_p1;
  assign host_rdata   = r_host_rdata_p1;
  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_dmem_arb6.sv
// tb_dmem_arb6: directed scenario bench for the shared data-memory arbiter.
module tb_dmem_arb6;

  logic       clk;
  logic       rst;
  logic       cpu_req, cpu_we;
  logic [2:0] cpu_addr;
  logic [5:0] cpu_wdata;
  logic       cpu_gnt, cpu_rvalid;
  logic [5:0] cpu_rdata;
  logic       host_req, host_we;
  logic [2:0] host_addr;
  logic [5:0] host_wdata;
  logic       host_gnt, host_rvalid;
  logic [5:0] host_rdata;
  logic       host_lock;
  logic [7:0] conflict_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_arb6 #(.DW(6), .AW(3), .LOCK_MAX(4), .CLR_ON_RST(1)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_lock(host_lock), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_req = 1'b1; host_req = 1'b1;
    #3;
    n_tests++;
    if (cpu_gnt !== 1'b0 || host_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_gnt: cpu_gnt=%b host_gnt=%b, required 0/0", cpu_gnt, host_gnt);
    end
    step(); step();
    rst = 1'b0; cpu_req = 1'b0; host_req = 1'b0;
    n_tests++;
    if (cpu_rvalid !== 1'b0 || host_rvalid !== 1'b0 || cpu_rdata !== 6'd0 ||
        host_rdata !== 6'd0 || conflict_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: rv=%b/%b rd=%0d/%0d cc=%0d, required 0", cpu_rvalid,
               host_rvalid, cpu_rdata, host_rdata, conflict_cnt);
    end
    step();
  endtask

  task automatic test_host_wr_rd();
    for (int a = 0; a < 8; a++) begin
      host_req = 1'b1; host_we = 1'b1; host_addr = 3'(a); host_wdata = 6'(a + 1);
      #3;
      n_tests++;
      if (host_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
        n_fail++;
        $display("FAIL host_wr_gnt a=%0d: host_gnt=%b cpu_gnt=%b, required 1/0", a, host_gnt, cpu_gnt);
      end
      step();
    end
    host_we = 1'b0; host_addr = 3'd5;
    step();
    host_req = 1'b0;
    n_tests++;
    if (host_rvalid !== 1'b1 || host_rdata !== 6'd6) begin
      n_fail++;
      $display("FAIL host_rd5: rvalid=%b rdata=%0d, required 1/6", host_rvalid, host_rdata);
    end
    step();
    n_tests++;
    if (host_rvalid !== 1'b0 || host_rdata !== 6'd6) begin
      n_fail++;
      $display("FAIL host_rd5_hold: rvalid=%b rdata=%0d, required 0/6", host_rvalid, host_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic exp_cpu;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 3'd2;
    for (int i = 0; i < 6; i++) begin
      exp_cpu = (i % 2 == 0);
      #3;
      n_tests++;
      if (cpu_gnt !== exp_cpu || host_gnt !== !exp_cpu) begin
        n_fail++;
        $display("FAIL rr_gnt i=%0d: cpu_gnt=%b host_gnt=%b, required %b/%b", i, cpu_gnt,
                 host_gnt, exp_cpu, !exp_cpu);
      end
      step();
    end
    cpu_req = 1'b0; host_req = 1'b0;
    n_tests++;
    if (conflict_cnt !== 8'd6 || cpu_rdata !== 6'd2 || host_rdata !== 6'd3) begin
      n_fail++;
      $display("FAIL rr_result: cc=%0d cpu_rdata=%0d host_rdata=%0d, required 6/2/3",
               conflict_cnt, cpu_rdata, host_rdata);
    end
  endtask

  task automatic test_lock();
    int exp_h [12];
    exp_h = '{0, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    host_lock = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 3'd2;
    for (int i = 0; i < 12; i++) begin
      #3;
      n_tests++;
      if (host_gnt !== exp_h[i][0] || cpu_gnt !== !exp_h[i][0]) begin
        n_fail++;
        $display("FAIL lock_gnt i=%0d: host_gnt=%b cpu_gnt=%b, required host=%0d", i,
                 host_gnt, cpu_gnt, exp_h[i]);
      end
      step();
    end
    cpu_req = 1'b0; host_req = 1'b0; host_lock = 1'b0;
    n_tests++;
    if (conflict_cnt !== 8'd18) begin
      n_fail++;
      $display("FAIL lock_cc: cc=%0d, required 18", conflict_cnt);
    end
  endtask

  task automatic test_back_to_back();
    host_req = 1'b1; host_we = 1'b1; host_addr = 3'd0; host_wdata = 6'd63;
    step();
    host_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd0;
    #3;
    n_tests++;
    if (cpu_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_cpu_gnt: cpu_gnt=%b, required 1", cpu_gnt);
    end
    step();
    n_tests++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 6'd63) begin
      n_fail++;
      $display("FAIL b2b_cpu_rd: rvalid=%b rdata=%0d, required 1/63", cpu_rvalid, cpu_rdata);
    end
    // Conflict after a CPU win: host read goes first and sees the old word.
    cpu_we = 1'b1; cpu_addr = 3'd3; cpu_wdata = 6'd2;
    host_req = 1'b1; host_we = 1'b0; host_addr = 3'd3;
    #3;
    n_tests++;
    if (host_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL order1_gnt: host_gnt=%b cpu_gnt=%b, required 1/0", host_gnt, cpu_gnt);
    end
    step();
    host_req = 1'b0;
    n_tests++;
    if (host_rvalid !== 1'b1 || host_rdata !== 6'd4) begin
      n_fail++;
      $display("FAIL order1_rd: rvalid=%b rdata=%0d, required 1/4", host_rvalid, host_rdata);
    end
    #3;
    n_tests++;
    if (cpu_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL order1_cpu_gnt: cpu_gnt=%b, required 1", cpu_gnt);
    end
    step();
    cpu_req = 1'b0;
    n_tests++;
    if (cpu_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_no_rvalid: cpu_rvalid=%b, required 0", cpu_rvalid);
    end
    host_req = 1'b1;
    step();
    n_tests++;
    if (host_rvalid !== 1'b1 || host_rdata !== 6'd2) begin
      n_fail++;
      $display("FAIL order1_after: rvalid=%b rdata=%0d, required 1/2", host_rvalid, host_rdata);
    end
    // Conflict after a host win: CPU write goes first, host then reads new word.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 3'd3; cpu_wdata = 6'd5;
    #3;
    n_tests++;
    if (cpu_gnt !== 1'b1 || host_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL order2_gnt: cpu_gnt=%b host_gnt=%b, required 1/0", cpu_gnt, host_gnt);
    end
    step();
    cpu_req = 1'b0;
    step();
    host_req = 1'b0;
    n_tests++;
    if (host_rvalid !== 1'b1 || host_rdata !== 6'd5 || conflict_cnt !== 8'd20) begin
      n_fail++;
      $display("FAIL order2_rd: rvalid=%b rdata=%0d cc=%0d, required 1/5/20", host_rvalid,
               host_rdata, conflict_cnt);
    end
  endtask

  task automatic test_rst_mid_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd1;
    step();
    cpu_req = 1'b0; rst = 1'b1;
    n_tests++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 6'd2) begin
      n_fail++;
      $display("FAIL pre_rst_rd: rvalid=%b rdata=%0d, required 1/2", cpu_rvalid, cpu_rdata);
    end
    step();
    rst = 1'b0;
    n_tests++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 6'd0 || conflict_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_rst: rvalid=%b rdata=%0d cc=%0d, required 0/0/0", cpu_rvalid,
               cpu_rdata, conflict_cnt);
    end
    for (int a = 0; a < 8; a++) begin
      host_req = 1'b1; host_we = 1'b0; host_addr = 3'(a);
      step();
      n_tests++;
      if (host_rvalid !== 1'b1 || host_rdata !== 6'd0) begin
        n_fail++;
        $display("FAIL mem_clr a=%0d: rvalid=%b rdata=%0d, required 1/0", a, host_rvalid, host_rdata);
      end
    end
    host_req = 1'b0;
    step();
  endtask

  task automatic test_saturate();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 3'd0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 3'd1;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 254) begin
        n_tests++;
        if (conflict_cnt !== 8'd254) begin
          n_fail++;
          $display("FAIL cc_254: cc=%0d, required 254", conflict_cnt);
        end
      end
      if (i == 255 || i == 300) begin
        n_tests++;
        if (conflict_cnt !== 8'd255) begin
          n_fail++;
          $display("FAIL cc_sat i=%0d: cc=%0d, required 255", i, conflict_cnt);
        end
      end
    end
    cpu_req = 1'b0; host_req = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; host_lock = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    #1;
    test_reset();
    test_host_wr_rd();
    test_round_robin();
    test_lock();
    test_back_to_back();
    test_rst_mid_read();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
